bar_scan_ctrl: RTL
==================

# bar_scan_ctrl

Scan controller for the 4-column LED bar display of the audio synthesizer. Holds one level value per column in a double-buffered register bank and time-multiplexes the display. Each column is driven in turn with a one-hot column select and a thermometer-coded row pattern, with a blanking gap between columns to suppress ghosting. Level producers (meter/envelope logic) write a shadow bank and request a commit. The new values take effect atomically at the next frame boundary.

## Interface
- CLK_DIV, 16: clock cycles per column slot; must be > BLANK_CYC.
- BLANK_CYC, 2: cycles at the start of each slot with all columns off; must be ≥ 1.
- ROWS, 8: row outputs per column.
- LVL_W, 4: level word width.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; low forces the display dark.
- lvl_we  in  1  write strobe for the shadow bank.
- lvl_idx  in  2  column written by lvl_we.
- lvl_data  in  LVL_W  level value written by lvl_we.
- commit  in  1  one-cycle request to copy shadow to active at the next frame boundary.
- col  out  4  one-hot column select, active high.
- row  out  ROWS  thermometer row pattern for the selected column.
- frame_start  out  1  one-cycle pulse on entry to column 0 blanking.
- commit_done  out  1  one-cycle pulse on the cycle the active bank was updated.

## Operation
- FSM states:
  - IDLE: col = 0, row = 0, cyc = 0, idx = 0.
  - BLANK: cyc 0..BLANK_CYC-1, col = 0, row = 0.
  - DRIVE: cyc BLANK_CYC..CLK_DIV-1, col = 1<<idx, row = therm(active[idx]).
- IDLE → BLANK when enable = 1; idx = 0, and this entry is a frame boundary.
- BLANK → DRIVE when cyc = BLANK_CYC-1.
- DRIVE → BLANK when cyc = CLK_DIV-1; idx increments mod 4. Wrap 3→0 is a frame boundary.
- enable = 0 in any state: the next edge goes to IDLE and outputs go dark.
- Thermometer encoding: row[i] = 1 when level > i. Levels ≥ ROWS saturate to all ones; level 0 gives all zeros.
- lvl_we writes shadow[lvl_idx] in any state, including IDLE.
- commit sets commit_pending.
- At a frame-boundary edge with (commit_pending | commit):
  - active ← shadow, all four entries at once.
  - commit_pending clears.
  - commit_done pulses.
- A lvl_we in the cycle of the boundary edge updates shadow only; the copy takes the pre-write shadow value.
- A commit in the cycle of the boundary edge is honoured immediately, not deferred.
- commit while already pending has no extra effect.
- Reset mid-scan: immediate return to IDLE; shadow, active and commit_pending are cleared.

## Timing
- Reset values: col = 0, row = 0, frame_start = 0, commit_done = 0, state IDLE, all banks 0.
- All outputs are registered and change only on clk edges.
- enable sampled high at edge k: state is BLANK after edge k, frame_start = 1 for that one cycle. col becomes 0001 after edge k+BLANK_CYC.
- Column period is CLK_DIV cycles; frame period is 4·CLK_DIV cycles. col is high for CLK_DIV-BLANK_CYC cycles per slot.
- The active bank switches on the same edge as frame_start. The first DRIVE slot after the switch shows the new values.
- Latency from commit to visible effect is at most 4·CLK_DIV + BLANK_CYC cycles.
- No two bits of col are ever high together, and col never changes directly from one non-zero value to another.

## Structure
- Package bar_pkg holds:
  - ROWS and LVL_W defaults.
  - State typedef {IDLE, BLANK, DRIVE}.
  - Column index typedef (2 bits).
- Sub-module bar_therm is purely combinational: LVL_W level in, ROWS thermometer out.
- One instance of bar_therm is fed by the mux active[idx].
- The top level contains the FSM, the cyc/idx counters, both banks and the commit logic.

## Test plan
- Reset mid-DRIVE of column 2 (CLK_DIV = 16, BLANK_CYC = 2) → next cycle col = 0, row = 0. After release with enable = 1, frame_start pulses and col0 is asserted 2 cycles later.
- Shadow = {3, 0, 8, 15}, commit, wait one frame → rows in order:
  - col0: 00000111
  - col1: 00000000
  - col2: 11111111
  - col3: 11111111 (saturation)
- Write shadow[1] = 5 without commit → col1 row stays unchanged for 3 frames. Then commit → commit_done coincides with the next frame_start, and col1 row = 00011111.
- lvl_we (idx 0, value 7) and commit both in the boundary cycle, with shadow[0] = 2 before → active[0] = 2, commit_done = 1, and shadow[0] = 7 after the edge.
- enable deasserted mid-slot → dark from the next cycle. Re-enable → scan restarts at column 0 with frame_start, and a commit pending from before is applied on that frame_start.
- Monitor over 10 frames → col is always one-hot or zero, slot length is 16 cycles, the blank gap is 2 cycles, and frame_start period is 64 cycles.

Source files
------------

// File: rtl/bar_pkg.sv
// Shared types and default parameters for the LED bar scan controller.
package bar_pkg;

  localparam int CLK_DIV_DEF   = 16;
  localparam int BLANK_CYC_DEF = 2;
  localparam int ROWS_DEF      = 8;
  localparam int LVL_W_DEF     = 4;
  localparam int NUM_COLS      = 4;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  typedef logic [1:0] col_idx_t;

endpackage

// File: rtl/bar_therm.sv
// Level to thermometer code: bit i lights when level > i, saturating at all ones.
module bar_therm #(
  parameter int LVL_W = 4,
  parameter int ROWS  = 8
) (
  input  logic [LVL_W-1:0] i_level,
  output logic [ROWS-1:0]  o_row
);

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign o_row[gi] = (32'(i_level) > 32'(gi));
    end
  endgenerate

endmodule

// File: rtl/bar_scan_ctrl.sv
// Column scan FSM for the 4-column LED bar, with a shadow/active level bank
// that swaps atomically at frame boundaries.
module bar_scan_ctrl
  import bar_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int LVL_W     = LVL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             lvl_we,
  input  logic [1:0]       lvl_idx,
  input  logic [LVL_W-1:0] lvl_data,
  input  logic             commit,
  output logic [3:0]       col,
  output logic [ROWS-1:0]  row,
  output logic             frame_start,
  output logic             commit_done
);

  localparam int CYC_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CYC_W-1:0] SLOT_LAST  = CYC_W'(CLK_DIV - 1);
  localparam logic [CYC_W-1:0] BLANK_LAST = CYC_W'(BLANK_CYC - 1);

  state_t           r_state;
  logic [CYC_W-1:0] r_cyc;
  col_idx_t         r_idx;
  logic [LVL_W-1:0] r_shadow [NUM_COLS];
  logic [LVL_W-1:0] r_active [NUM_COLS];
  logic             r_pending;

  logic             w_slot_end;
  logic             w_boundary;
  logic [LVL_W-1:0] w_level;
  logic [ROWS-1:0]  w_therm;

  assign w_slot_end = (r_state == DRIVE) && (r_cyc == SLOT_LAST);
  // Frame boundary: leaving IDLE, or finishing column 3, with the scan still enabled.
  assign w_boundary = enable && ((r_state == IDLE) || (w_slot_end && (r_idx == 2'd3)));
  assign w_level    = r_active[r_idx];

  bar_therm #(
    .LVL_W (LVL_W),
    .ROWS  (ROWS)
  ) u_therm (
    .i_level (w_level),
    .o_row   (w_therm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cyc       <= '0;
      r_idx       <= '0;
      col         <= '0;
      row         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!enable) begin
        r_state <= IDLE;
        r_cyc   <= '0;
        r_idx   <= '0;
        col     <= '0;
        row     <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state     <= BLANK;
            r_cyc       <= '0;
            r_idx       <= '0;
            col         <= '0;
            row         <= '0;
            frame_start <= 1'b1;
          end
          BLANK: begin
            r_cyc <= r_cyc + 1'b1;
            if (r_cyc == BLANK_LAST) begin
              r_state <= DRIVE;
              col     <= 4'(1) << r_idx;
              row     <= w_therm;
            end
          end
          DRIVE: begin
            if (w_slot_end) begin
              r_state     <= BLANK;
              r_cyc       <= '0;
              r_idx       <= r_idx + 2'd1;
              col         <= '0;
              row         <= '0;
              frame_start <= (r_idx == 2'd3);
            end else begin
              r_cyc <= r_cyc + 1'b1;
              row   <= w_therm;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_idx   <= '0;
            col     <= '0;
            row     <= '0;
          end
        endcase
      end
    end
  end

  // Non-blocking copy means a same-edge lvl_we lands in shadow only; active gets the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_pending   <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      if (lvl_we) begin
        r_shadow[lvl_idx] <= lvl_data;
      end
      if (w_boundary && (r_pending || commit)) begin
        for (int i = 0; i < NUM_COLS; i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_pending   <= 1'b0;
        commit_done <= 1'b1;
      end else if (commit) begin
        r_pending <= 1'b1;
      end
    end
  end

endmodule
